// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit between execute and writeback.
//   Steers bytes to lanes and generates byte enables. Flags misaligned
//   accesses and illegal funct3 values. Posts stores into a STB_DEPTH-entry
//   buffer that drains on its own write channel. Loads go out on the read
//   channel, but a load whose bus word matches a buffered store waits for
//   that store to drain first.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_rdy            request handshake
//   in_op/in_funct3            operation (00/11 none, 01 load, 10 store) and RV funct3
//   in_addr/in_wdata/in_tag    byte address, right-justified store data, passthrough tag
//   out_valid/out_rdy          result handshake
//   out_data/out_tag/out_fault extended load data (0 otherwise), tag, fault flag
//   rd_req_*/rd_rsp_*          read channel (bus-aligned address)
//   wr_req_*/wr_rsp_done       write channel (bus-aligned address, lane data, byte enables)
//
// state   | meaning
// IDLE    | ready for a request
// LD_HOLD | load waits for a matching buffered store to drain
// LD_WAIT | read request outstanding
module lsu_stage #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 5,
    parameter int STB_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_rdy,
    input  logic [1:0]          in_op,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_rdy,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_fault,
    output logic                rd_req_en,
    output logic [ADDR_W-1:0]   rd_req_addr,
    input  logic                rd_rsp_done,
    input  logic [DATA_W-1:0]   rd_rsp_data,
    output logic                wr_req_en,
    output logic [ADDR_W-1:0]   wr_req_addr,
    output logic [DATA_W-1:0]   wr_req_data,
    output logic [DATA_W/8-1:0] wr_req_be,
    input  logic                wr_rsp_done
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = $clog2(STB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LD_HOLD = 2'd1, LD_WAIT = 2'd2} state_t;
    state_t state, state_nxt;

    logic [OFF_W-1:0]  in_off;
    logic [ADDR_W-1:0] in_bus_addr;
    logic [3:0]        off4, acc_size;
    logic              f3_legal, misaligned, is_mem, req_fault, req_load, req_store;

    assign in_off      = in_addr[OFF_W-1:0];
    assign in_bus_addr = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign off4        = 4'(in_off);
    assign acc_size    = 4'd1 << in_funct3[1:0];
    assign misaligned  = ((off4 & (acc_size - 4'd1)) != 4'd0) ||
                         ((5'(off4) + 5'(acc_size)) > 5'(BE_W));
    assign is_mem      = (in_op == 2'b01) || (in_op == 2'b10);

    always_comb begin
        f3_legal = 1'b0;
        if (in_op == 2'b01) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                3'b011, 3'b110:                         f3_legal = (DATA_W == 64);
                default:                                f3_legal = 1'b0;
            endcase
        end else if (in_op == 2'b10) begin
            case (in_funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                3'b011:                 f3_legal = (DATA_W == 64);
                default:                f3_legal = 1'b0;
            endcase
        end
    end

    assign req_fault = is_mem && (!f3_legal || misaligned);
    assign req_load  = (in_op == 2'b01) && !req_fault;
    assign req_store = (in_op == 2'b10) && !req_fault;

    // Store buffer: circular FIFO; per-entry valid bits feed the load address match.
    logic [ADDR_W-1:0]    stb_addr [STB_DEPTH];
    logic [DATA_W-1:0]    stb_data [STB_DEPTH];
    logic [BE_W-1:0]      stb_be   [STB_DEPTH];
    logic [STB_DEPTH-1:0] stb_vld;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     stb_cnt;
    logic                 stb_full, accept, push, pop, stb_hit;
    logic [ADDR_W-1:0]    hit_addr;
    logic [DATA_W-1:0]    st_data;
    logic [BE_W-1:0]      st_be;

    logic [ADDR_W-1:0] ld_addr;
    logic [OFF_W-1:0]  ld_off;
    logic [2:0]        ld_f3;
    logic [TAG_W-1:0]  ld_tag;

    assign stb_full = (stb_cnt == CNT_W'(STB_DEPTH));
    assign in_rdy   = (state == IDLE) && (!out_valid || out_rdy) && !stb_full;
    assign accept   = in_valid && in_rdy;
    assign push     = accept && req_store;
    assign pop      = wr_req_en && wr_rsp_done;
    assign st_data  = in_wdata << {in_off, 3'b000};

    always_comb begin
        st_be = '0;
        for (int i = 0; i < BE_W; i++) begin
            st_be[i] = (4'(i) >= off4) && (4'(i) < (off4 + acc_size));
        end
    end

    // In IDLE the incoming load is matched; afterwards the held load is.
    assign hit_addr = (state == IDLE) ? in_bus_addr : ld_addr;

    always_comb begin
        stb_hit = 1'b0;
        for (int i = 0; i < STB_DEPTH; i++) begin
            if (stb_vld[i] && (stb_addr[i] == hit_addr)) stb_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            stb_addr[wr_ptr] <= in_bus_addr;
            stb_data[wr_ptr] <= st_data;
            stb_be[wr_ptr]   <= st_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            stb_cnt     <= '0;
            stb_vld     <= '0;
            wr_req_en   <= 1'b0;
            wr_req_addr <= '0;
            wr_req_data <= '0;
            wr_req_be   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   stb_cnt <= stb_cnt + 1'b1;
                2'b01:   stb_cnt <= stb_cnt - 1'b1;
                default: stb_cnt <= stb_cnt;
            endcase
            if (pop)  stb_vld[rd_ptr] <= 1'b0;
            if (push) stb_vld[wr_ptr] <= 1'b1;
            // A pop forces a one-cycle gap, so the next head is presented fresh.
            if (pop) begin
                wr_req_en   <= 1'b0;
                wr_req_addr <= '0;
                wr_req_data <= '0;
                wr_req_be   <= '0;
            end else if (!wr_req_en && (stb_cnt != '0)) begin
                wr_req_en   <= 1'b1;
                wr_req_addr <= stb_addr[rd_ptr];
                wr_req_data <= stb_data[rd_ptr];
                wr_req_be   <= stb_be[rd_ptr];
            end
        end
    end

    logic              rd_en_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;

    always_comb begin
        state_nxt   = state;
        rd_en_nxt   = rd_req_en;
        rd_addr_nxt = rd_req_addr;
        case (state)
            IDLE: begin
                if (accept && req_load) begin
                    if (stb_hit) begin
                        state_nxt = LD_HOLD;
                    end else begin
                        state_nxt   = LD_WAIT;
                        rd_en_nxt   = 1'b1;
                        rd_addr_nxt = in_bus_addr;
                    end
                end
            end
            LD_HOLD: begin
                if (!stb_hit) begin
                    state_nxt   = LD_WAIT;
                    rd_en_nxt   = 1'b1;
                    rd_addr_nxt = ld_addr;
                end
            end
            LD_WAIT: begin
                if (rd_rsp_done) begin
                    state_nxt   = IDLE;
                    rd_en_nxt   = 1'b0;
                    rd_addr_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                rd_en_nxt   = 1'b0;
                rd_addr_nxt = '0;
            end
        endcase
    end

    logic [DATA_W-1:0] ld_shift, ld_result;
    assign ld_shift = rd_rsp_data >> {ld_off, 3'b000};

    always_comb begin
        ld_result = '0;
        case (ld_f3)
            3'b000:  ld_result = DATA_W'($signed(ld_shift[7:0]));
            3'b001:  ld_result = DATA_W'($signed(ld_shift[15:0]));
            3'b010:  ld_result = DATA_W'($signed(ld_shift[31:0]));
            3'b011:  ld_result = ld_shift;
            3'b100:  ld_result = DATA_W'(ld_shift[7:0]);
            3'b101:  ld_result = DATA_W'(ld_shift[15:0]);
            3'b110:  ld_result = DATA_W'(ld_shift[31:0]);
            default: ld_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_req_en   <= 1'b0;
            rd_req_addr <= '0;
            ld_addr     <= '0;
            ld_off      <= '0;
            ld_f3       <= '0;
            ld_tag      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_fault   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_req_en   <= rd_en_nxt;
            rd_req_addr <= rd_addr_nxt;
            if (accept && req_load) begin
                ld_addr <= in_bus_addr;
                ld_off  <= in_off;
                ld_f3   <= in_funct3;
                ld_tag  <= in_tag;
            end
            // Accepts only happen with the output register free, so the
            // two result sources never collide.
            if (accept && !req_load) begin
                out_valid <= 1'b1;
                out_data  <= '0;
                out_tag   <= in_tag;
                out_fault <= req_fault;
            end else if ((state == LD_WAIT) && rd_rsp_done) begin
                out_valid <= 1'b1;
                out_data  <= ld_result;
                out_tag   <= ld_tag;
                out_fault <= 1'b0;
            end else if (out_rdy) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
